// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop recovery with runtime frame format.
// Ports: clk, reset (async active-low), s_tick, rx, d_bits, stop_ticks,
//        dout (right-justified data), rx_done (1-clk pulse), frame_err.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int OVRSAMPLING = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 rx,
    input  logic [3:0]           d_bits,
    input  logic [5:0]           stop_ticks,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done,
    output logic                 frame_err
);

    localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [3:0] DB      = 4'(DATA_BITS);
    localparam logic [5:0] S_MID   = 6'(OVRSAMPLING / 2 - 1);
    localparam logic [5:0] S_LAST  = 6'(OVRSAMPLING - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state, state_n;
    logic [5:0]           s_reg, s_n;
    logic [NW-1:0]        n_reg, n_n;
    logic [DATA_BITS-1:0] b_reg, b_n;
    logic [DATA_BITS-1:0] dout_n;
    logic                 fe_n;
    logic                 done_n;
    logic                 rx_meta, rx_sync;
    logic [3:0]           d_eff;

    // Out-of-range word lengths fall back to the full data width.
    always_comb begin
        if (d_bits < 4'd5 || d_bits > DB)
            d_eff = DB;
        else
            d_eff = d_bits;
    end

    // Two-flop synchronizer, reset to the idle (mark) level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            dout      <= '0;
            frame_err <= 1'b0;
            rx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            s_reg     <= s_n;
            n_reg     <= n_n;
            b_reg     <= b_n;
            dout      <= dout_n;
            frame_err <= fe_n;
            rx_done   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s_reg;
        n_n     = n_reg;
        b_n     = b_reg;
        dout_n  = dout;
        fe_n    = frame_err;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == S_MID) begin
                        // A high line at mid start bit is a glitch.
                        if (!rx_sync) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s_reg + 6'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_LAST) begin
                        s_n = '0;
                        b_n = {rx_sync, b_reg[DATA_BITS-1:1]};
                        if (4'(n_reg) == d_eff - 4'd1)
                            state_n = STOP;
                        else
                            n_n = n_reg + NW'(1);
                    end else begin
                        s_n = s_reg + 6'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == stop_ticks - 6'd1) begin
                        state_n = IDLE;
                        // Short words sit in the top of b_reg.
                        dout_n  = b_reg >> (DB - d_eff);
                        fe_n    = ~rx_sync;
                        done_n  = 1'b1;
                    end else begin
                        s_n = s_reg + 6'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are queued as expected words by the
// driver and matched against rx_done pulses by a monitor.
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       rx;
    logic [3:0] d_bits;
    logic [5:0] stop_ticks;
    logic [7:0] dout;
    logic       rx_done;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        int         t;
        int         n;
        int         s;
    } exp_t;

    exp_t q[$];

    logic [7:0] last_dout = '0;
    logic       last_fe   = 1'b0;
    logic       prev_done = 1'b0;

    uart_rx #(.DATA_BITS(8), .OVRSAMPLING(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_tick     (s_tick),
        .rx         (rx),
        .d_bits     (d_bits),
        .stop_ticks (stop_ticks),
        .dout       (dout),
        .rx_done    (rx_done),
        .frame_err  (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 s_tick = 1'b1;
            @(posedge clk);
            #1 s_tick = 1'b0;
        end
    end

    // Monitor: compares each done pulse with the oldest queued frame,
    // and checks outputs hold between pulses.
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_dout", 32'(dout), 0);
            check("rst_done", 32'(rx_done), 0);
            check("rst_ferr", 32'(frame_err), 0);
            last_dout = '0;
            last_fe   = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (rx_done) begin
                check("done_width", 32'(prev_done), 0);
                if (q.size() == 0) begin
                    check("spurious_done", 32'(rx_done), 0);
                end else begin
                    exp_t e;
                    int   lag;
                    e   = q.pop_front();
                    lag = cyc - e.t - (32 + 64 * e.n + 4 * e.s);
                    check("dout", 32'(dout), 32'(e.data));
                    check("frame_err", 32'(frame_err), 32'(e.fe));
                    check("done_timing", 32'(lag >= -2 && lag <= 8), 1);
                    last_dout = e.data;
                    last_fe   = e.fe;
                end
            end else begin
                check("dout_hold", 32'(dout), 32'(last_dout));
                check("ferr_hold", 32'(frame_err), 32'(last_fe));
            end
            prev_done = rx_done;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic [3:0] d,
                              input int s, input bit bad, input int gap);
        int         n;
        exp_t       e;
        logic [7:0] mask;
        n          = (d < 5 || d > 8) ? 8 : int'(d);
        mask       = 8'((1 << n) - 1);
        d_bits     = d;
        stop_ticks = 6'(s);
        e.data     = data & mask;
        e.fe       = bad;
        e.t        = cyc;
        e.n        = n;
        e.s        = s;
        q.push_back(e);
        rx = 1'b0;
        wait_clks(64);
        for (int i = 0; i < n; i++) begin
            rx = data[i];
            wait_clks(64);
        end
        if (bad) begin
            rx = 1'b0;
            wait_clks(4 * s - 24);
            rx = 1'b1;
            wait_clks(24 + 64);
        end else begin
            rx = 1'b1;
            wait_clks(4 * s);
        end
        rx = 1'b1;
        wait_clks(gap);
    endtask

    initial begin
        int   s_opt[3];
        bit   prev_bad;
        logic [7:0] rd;
        s_opt[0] = 16;
        s_opt[1] = 24;
        s_opt[2] = 32;
        reset      = 1'b0;
        rx         = 1'b1;
        d_bits     = 4'd8;
        stop_ticks = 6'd16;
        wait_clks(5);
        reset = 1'b1;
        wait_clks(20);

        send_frame(8'hA5, 4'd8, 16, 1'b0, 40);
        send_frame(8'h55, 4'd7, 16, 1'b0, 40);
        send_frame(8'h13, 4'd5, 16, 1'b0, 40);

        rx = 1'b0;
        wait_clks(20);
        rx = 1'b1;
        wait_clks(64);
        check("glitch_no_done", 32'(q.size()), 0);
        send_frame(8'h3C, 4'd8, 16, 1'b0, 40);

        send_frame(8'h81, 4'd8, 16, 1'b1, 40);
        send_frame(8'h7E, 4'd8, 16, 1'b0, 40);

        send_frame(8'h00, 4'd8, 32, 1'b0, 0);
        send_frame(8'hFF, 4'd8, 32, 1'b0, 0);
        send_frame(8'h5A, 4'd8, 32, 1'b0, 40);

        // Abort a frame in the middle of data bit 3.
        rx = 1'b0;
        wait_clks(64);
        rd = 8'hB6;
        for (int i = 0; i < 3; i++) begin
            rx = rd[i];
            wait_clks(64);
        end
        rx = rd[3];
        wait_clks(32);
        reset = 1'b0;
        rx    = 1'b1;
        wait_clks(8);
        reset = 1'b1;
        wait_clks(64);
        send_frame(8'hC3, 4'd8, 16, 1'b0, 40);

        prev_bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            bit bad;
            int gap;
            bad = ($urandom_range(0, 99) < 15);
            gap = $urandom_range(0, 80);
            if ($urandom_range(0, 2) == 0)
                gap = 0;
            send_frame(8'($urandom), 4'($urandom_range(0, 15)),
                       s_opt[$urandom_range(0, 2)], bad, gap);
            prev_bad = bad;
        end
        wait_clks(40);

        for (int i = 0; i < 2000 && q.size() != 0; i++)
            wait_clks(1);
        check("queue_drained", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that recovers serial frames from the external rx line and presents parallel data to the processor. It uses the shared baud-rate generator tick, nominally 16 ticks per bit. It takes the same runtime frame-format inputs (d_bits, stop_ticks) as the transmitter, so both ends of a link use one configuration register. Per frame it raises a one-cycle done pulse, with held data and a framing-error flag.

Parameters:
DATA_BITS, 8, maximum data bits per frame and width of dout
OVRSAMPLING, 16, s_tick pulses per bit period

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
s_tick  input  1  one-clk-wide oversampling tick from baud-rate generator
rx  input  1  serial input line, asynchronous to clk, idle high
d_bits  input  4  data bits per frame, legal 5..DATA_BITS
stop_ticks  input  6  stop-bit length in ticks (16 = 1 bit, 24 = 1.5 bits, 32 = 2 bits)
dout  output  DATA_BITS  received data, LSB-first reassembled, right-justified
rx_done  output  1  one-clk pulse: frame complete, dout/frame_err updated
frame_err  output  1  stop bit sampled low on last completed frame

Behaviour:
- Reset (reset low, async assert, sync release):
  - state = idle; all counters 0; shift register 0.
  - Both synchronizer flops = 1.
  - dout = 0, rx_done = 0, frame_err = 0.
- rx passes through a 2-flop synchronizer (rx_sync). All sampling uses rx_sync only. This adds 2 clk of input latency.
- Counters:
  - s_reg is 6 bits, counts ticks.
  - n_reg is 3 bits, counts data bits.
  - b_reg is DATA_BITS wide, the shift register.
- States:
  - idle:
    - If rx_sync == 0, go to start with s = 0. Otherwise hold.
    - s_tick is not required to leave idle.
  - start:
    - On s_tick with s == OVRSAMPLING/2-1 (7), i.e. at mid start bit:
      - If rx_sync == 0, go to data with s = 0, n = 0.
      - Else treat as a glitch: return to idle with no rx_done.
    - Other ticks: s++.
  - data:
    - On s_tick with s == OVRSAMPLING-1, i.e. at mid-bit:
      - s = 0.
      - b_reg = {rx_sync, b_reg[DATA_BITS-1:1]}.
      - If n == d_bits-1, go to stop. Else n++.
    - Other ticks: s++.
  - stop:
    - On s_tick with s == stop_ticks-1:
      - Go to idle.
      - Register dout = b_reg >> (DATA_BITS - d_bits).
      - Register frame_err = ~rx_sync.
      - Register rx_done = 1.
    - Other ticks: s++.
- rx_done timing:
  - High for exactly one clk, in the cycle after the final stop tick.
  - dout and frame_err change only in that same cycle and hold until the next completed frame.
- d_bits out of range (0..4 or > DATA_BITS) is treated as DATA_BITS. Implement this with an internal clamp.
- d_bits and stop_ticks are sampled continuously. Software changes them only while idle; a mid-frame change gives an undefined frame but no lockup. The state always returns to idle within one frame time.
- A frame with a framing error still delivers data and pulses rx_done. There is no retry.
- Back-to-back frames: idle is re-entered on the stop-completion cycle, so a start edge immediately after is accepted with no dead cycles.
- rx held low (break): after a frame with frame_err = 1, the FSM re-enters start/data repeatedly. Each resulting frame reports dout = 0, frame_err = 1.
- Reset asserted mid-frame aborts immediately to the reset values. No rx_done is produced for the partial frame.

Test Plan:
- Tick every 4 clk, d_bits = 8, stop_ticks = 16; drive 0xA5 LSB-first with 64-clk bit periods -> single rx_done pulse, dout = 0xA5, frame_err = 0, and rx_done occurs 8 ticks into the stop bit.
- d_bits = 7, send 0x55 (7 bits), then d_bits = 5, send 0x13 -> dout = 0x55 then 0x13, right-justified, upper bits 0.
- rx low for 5 ticks only, then high -> no rx_done; state returns to idle; next valid frame 0x3C is received correctly.
- Send 0x81 with stop bit driven low -> rx_done pulse, dout = 0x81, frame_err = 1; next good frame 0x7E clears frame_err to 0.
- Back-to-back frames 0x00, 0xFF, 0x5A with no idle gap, stop_ticks = 32 -> three rx_done pulses in order with the correct dout values.
- Assert reset (low) in the middle of data bit 3 of a frame, release, then send 0xC3 -> all outputs 0 during reset, no spurious rx_done, then dout = 0xC3.
